// File: rtl/wbo_port_gen.sv
// Wishbone slave output port: byte-lane writes, SET/CLR/TGL atomic modes and
// a programmable wait-state ACK generator. PRT_O and DAT_O both show Q directly.
module wbo_port_gen #(
    parameter int              DAT_W       = 8,
    parameter int              WAIT_STATES = 0,
    parameter logic [DAT_W-1:0] RST_VAL    = '0
) (
    input  logic               CLK_I,
    input  logic               RST_I,
    input  logic               CYC_I,
    input  logic               STB_I,
    input  logic               WE_I,
    input  logic [1:0]         ADR_I,
    input  logic [DAT_W/8-1:0] SEL_I,
    input  logic [DAT_W-1:0]   DAT_I,
    output logic [DAT_W-1:0]   DAT_O,
    output logic               ACK_O,
    output logic [DAT_W-1:0]   PRT_O
);

    localparam int NLANES = DAT_W / 8;
    // Counter preload; only meaningful when WAIT_STATES > 0.
    localparam logic [3:0] WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    localparam logic [1:0] ADR_DATA = 2'd0;
    localparam logic [1:0] ADR_SET  = 2'd1;
    localparam logic [1:0] ADR_CLR  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [DAT_W-1:0] q_q, q_d;
    logic             req;
    logic             ack;
    logic             commit;

    assign req    = CYC_I & STB_I;
    assign ack    = (state_q == ST_ACK) & req;
    assign commit = ack & WE_I;

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            q_q     <= RST_VAL;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    if (WAIT_STATES > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_INIT;
                    end else begin
                        state_d = ST_ACK;
                    end
                end
            end
            ST_WAIT: begin
                // A dropped strobe abandons the beat; nothing is committed.
                if (!req) begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q == 4'd0) begin
                    state_d = ST_ACK;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    for (genvar gi = 0; gi < NLANES; gi++) begin : g_lane
        logic [7:0] cur_lane;
        logic [7:0] din_lane;
        logic [7:0] new_lane;

        assign cur_lane = q_q[gi*8 +: 8];
        assign din_lane = DAT_I[gi*8 +: 8];

        always_comb begin
            new_lane = cur_lane;
            case (ADR_I)
                ADR_DATA: new_lane = din_lane;
                ADR_SET:  new_lane = cur_lane | din_lane;
                ADR_CLR:  new_lane = cur_lane & ~din_lane;
                default:  new_lane = cur_lane ^ din_lane;
            endcase
        end

        assign q_d[gi*8 +: 8] = (commit && SEL_I[gi]) ? new_lane : cur_lane;
    end

    assign ACK_O = ack;
    assign DAT_O = q_q;
    assign PRT_O = q_q;

endmodule

// File: tb/tb_wbo_port_gen.sv
// Three port instances (0, 2 and 3 wait states) driven independently and
// compared every cycle against a beat-age/byte-mask reference model.
module tb_wbo_port_gen;

    localparam int          DW = 16;
    localparam int          NI = 3;
    localparam logic [15:0] RV = 16'hA5A5;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        cyc  [NI];
    logic        stb  [NI];
    logic        we   [NI];
    logic [1:0]  adr  [NI];
    logic [1:0]  sel  [NI];
    logic [15:0] dati [NI];
    logic [15:0] dato [NI];
    logic [15:0] prt  [NI];
    logic        ack  [NI];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        wbo_port_gen #(
            .DAT_W       (DW),
            .WAIT_STATES (gi == 0 ? 0 : (gi == 1 ? 2 : 3)),
            .RST_VAL     (RV)
        ) u_dut (
            .CLK_I (clk),
            .RST_I (rst_n),
            .CYC_I (cyc[gi]),
            .STB_I (stb[gi]),
            .WE_I  (we[gi]),
            .ADR_I (adr[gi]),
            .SEL_I (sel[gi]),
            .DAT_I (dati[gi]),
            .DAT_O (dato[gi]),
            .ACK_O (ack[gi]),
            .PRT_O (prt[gi])
        );
    end

    function automatic int ws_of(input int k);
        return (k == 0) ? 0 : ((k == 1) ? 2 : 3);
    endfunction

    // Reference: age = consecutive sampled request edges in the current beat.
    int          age [NI];
    logic [15:0] mq  [NI];

    function automatic logic exp_ack(input int k);
        return (age[k] == ws_of(k) + 1) && cyc[k] && stb[k];
    endfunction

    function automatic logic [15:0] apply(input logic [15:0] q, input logic [1:0] a,
                                          input logic [1:0] s, input logic [15:0] d);
        logic [15:0] m;
        logic [15:0] r;
        m = {{8{s[1]}}, {8{s[0]}}};
        case (a)
            2'd0:    r = d;
            2'd1:    r = q | d;
            2'd2:    r = q & ~d;
            default: r = q ^ d;
        endcase
        return (r & m) | (q & ~m);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NI; k++) begin
                age[k] <= 0;
                mq[k]  <= RV;
            end
        end else begin
            for (int k = 0; k < NI; k++) begin
                if (exp_ack(k)) begin
                    age[k] <= 0;
                    if (we[k]) mq[k] <= apply(mq[k], adr[k], sel[k], dati[k]);
                end else if (cyc[k] && stb[k]) begin
                    age[k] <= age[k] + 1;
                end else begin
                    age[k] <= 0;
                end
            end
        end
    end

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < NI; k++) begin
            check($sformatf("model_ack[%0d]", k), {15'd0, ack[k]}, {15'd0, exp_ack(k)});
            check($sformatf("model_prt[%0d]", k), prt[k], mq[k]);
            check($sformatf("model_dato[%0d]", k), dato[k], mq[k]);
        end
    end

    // One Wishbone beat on instance k; n = negedges seen up to and including ACK.
    task automatic beat(input int k, input logic w, input logic [1:0] a, input logic [1:0] s,
                        input logic [15:0] d, output int n, output logic [15:0] rd);
        bit seen;
        seen = 0;
        rd   = 16'h0;
        @(posedge clk); #1;
        cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = w; adr[k] = a; sel[k] = s; dati[k] = d;
        n = 0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (ack[k]) begin
                seen = 1;
                rd   = dato[k];
            end
        end
        if (!seen) check("beat_timeout", 16'd0, 16'd1);
        @(posedge clk); #1;
        cyc[k] = 1'b0; stb[k] = 1'b0;
        $display("beat inst=%0d we=%0b adr=%0d sel=%b dat=%h cycles=%0d", k, w, a, s, d, n);
    endtask

    initial begin
        int          n;
        logic [15:0] rd;
        int          acks;
        int          cnt;
        int          last;
        int          r;
        bit          seen;

        for (int k = 0; k < NI; k++) begin
            cyc[k] = 0; stb[k] = 0; we[k] = 0; adr[k] = 0; sel[k] = 0; dati[k] = 0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_prt", prt[1], 16'hA5A5);
        check("reset_ack", {15'd0, ack[1]}, 16'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Wait states: ACK three edges after the first sampled strobe.
        beat(1, 1'b1, 2'd0, 2'b11, 16'h1234, n, rd);
        check("ws2_latency", 16'(n), 16'd4);
        @(negedge clk);
        check("ws2_prt", prt[1], 16'h1234);
        check("ws2_ack_single", {15'd0, ack[1]}, 16'd0);

        // Reset in the middle of a wait phase.
        @(posedge clk); #1;
        cyc[1] = 1; stb[1] = 1; we[1] = 0; adr[1] = 0; sel[1] = 2'b11; dati[1] = 16'h0;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("midwait_rst_prt", prt[1], 16'hA5A5);
        check("midwait_rst_ack", {15'd0, ack[1]}, 16'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        n = 0; seen = 0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (ack[1]) seen = 1;
        end
        check("post_rst_latency", 16'(n), 16'd4);
        @(posedge clk); #1;
        cyc[1] = 0; stb[1] = 0;
        $display("post-reset read inst=1 cycles=%0d", n);

        // Byte lanes and atomic modes on the zero-wait instance.
        beat(0, 1'b1, 2'd0, 2'b11, 16'h00FF, n, rd);
        @(negedge clk); check("mode_init", prt[0], 16'h00FF);
        beat(0, 1'b1, 2'd1, 2'b10, 16'h0F00, n, rd);
        @(negedge clk); check("mode_set", prt[0], 16'h0FFF);
        beat(0, 1'b1, 2'd2, 2'b01, 16'h00F0, n, rd);
        @(negedge clk); check("mode_clr", prt[0], 16'h0F0F);
        beat(0, 1'b1, 2'd3, 2'b01, 16'hFFFF, n, rd);
        @(negedge clk); check("mode_tgl", prt[0], 16'h0FF0);
        beat(0, 1'b1, 2'd0, 2'b00, 16'hFFFF, n, rd);
        check("sel0_ack_latency", 16'(n), 16'd2);
        @(negedge clk); check("sel0_nochange", prt[0], 16'h0FF0);

        // Abort: strobe dropped before the fourth sampled edge.
        beat(2, 1'b1, 2'd0, 2'b11, 16'h5A5A, n, rd);
        check("ws3_latency", 16'(n), 16'd5);
        @(posedge clk); #1;
        cyc[2] = 1; stb[2] = 1; we[2] = 1; adr[2] = 0; sel[2] = 2'b11; dati[2] = 16'hBEEF;
        repeat (2) begin
            @(negedge clk);
            check("abort_no_ack_pre", {15'd0, ack[2]}, 16'd0);
        end
        @(posedge clk); #1;
        stb[2] = 0;
        repeat (6) begin
            @(negedge clk);
            check("abort_no_ack_post", {15'd0, ack[2]}, 16'd0);
        end
        check("abort_q", prt[2], 16'h5A5A);
        cyc[2] = 0;
        $display("abort inst=2 dat=beef q=%h", prt[2]);

        // Four-beat block write with the strobe held.
        @(posedge clk); #1;
        cyc[0] = 1; stb[0] = 1; we[0] = 1; adr[0] = 0; sel[0] = 2'b11; dati[0] = 16'd1;
        acks = 0; cnt = 0; last = -1;
        while (acks < 4 && cnt < 60) begin
            @(negedge clk);
            cnt++;
            if (ack[0]) begin
                acks++;
                if (last >= 0) check("burst_gap", 16'(cnt - last), 16'd2);
                $display("burst ack=%0d cycle=%0d dat=%h", acks, cnt, dati[0]);
                last = cnt;
                @(posedge clk); #1;
                if (acks < 4) dati[0] = 16'(acks + 1);
                else begin cyc[0] = 0; stb[0] = 0; end
            end
        end
        check("burst_acks", 16'(acks), 16'd4);
        @(negedge clk); check("burst_q", prt[0], 16'd4);
        beat(0, 1'b0, 2'd0, 2'b11, 16'hFFFF, n, rd);
        check("burst_read", rd, 16'd4);

        // Randomised traffic on all instances, including one asynchronous reset.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            for (int k = 0; k < NI; k++) begin
                r = $urandom_range(0, 9);
                cyc[k]  = (r < 8);
                stb[k]  = (r < 7) || (r == 8);
                we[k]   = 1'($urandom_range(0, 1));
                adr[k]  = 2'($urandom_range(0, 3));
                sel[k]  = 2'($urandom_range(0, 3));
                dati[k] = 16'($urandom);
            end
            if (c == 1500) begin
                #2 rst_n = 1'b0;
                @(posedge clk); #1 rst_n = 1'b1;
                $display("random phase reset at cycle %0d", c);
            end
        end
        @(posedge clk); #1;
        for (int k = 0; k < NI; k++) begin
            cyc[k] = 0; stb[k] = 0;
        end
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wbo_port_gen.md
Name: wbo_port_gen

Overview:
- Parametrised Wishbone slave output port; next generation of the team's fixed 8-bit output port.
- Generalised data width with byte-lane selects and a programmable wait-state ACK generator.
- Atomic SET/CLEAR/TOGGLE write modes remove read-modify-write on shared port bits.
- Sits on the peripheral Wishbone bus and drives `PRT_O` to board-level pins or other blocks.

Parameters:
- DAT_W, 8, data/port width in bits; must be a multiple of 8, range 8..64.
- WAIT_STATES, 0, extra cycles inserted before ACK_O; range 0..15.
- RST_VAL, 0, value loaded into the port register on reset (DAT_W bits).

Ports:
- CLK_I  in  1  system clock; all state changes on rising edge.
- RST_I  in  1  asynchronous, active-low reset.
- CYC_I  in  1  Wishbone bus cycle valid.
- STB_I  in  1  Wishbone strobe.
- WE_I  in  1  1 = write, 0 = read.
- ADR_I  in  2  register select: 0 DATA, 1 SET, 2 CLR, 3 TGL.
- SEL_I  in  DAT_W/8  byte-lane enables; bit n covers DAT bits 8n+7..8n.
- DAT_I  in  DAT_W  write data.
- DAT_O  out  DAT_W  read data = port register Q, all addresses.
- ACK_O  out  1  transfer acknowledge.
- PRT_O  out  DAT_W  port output = Q.

Behaviour:
- Reset: RST_I low asynchronously forces Q=RST_VAL, FSM=IDLE, wait counter=0. Outputs are then ACK_O=0, DAT_O=PRT_O=RST_VAL.
- Reset release: synchronous to CLK_I.
- Request: REQ = CYC_I & STB_I.
- FSM states IDLE, WAIT, ACK:
  - IDLE: on REQ go to WAIT with counter=WAIT_STATES-1 if WAIT_STATES>0, else go to ACK.
  - WAIT: if REQ drops, go to IDLE (abort, no write). Else if counter=0, go to ACK. Else decrement the counter.
  - ACK: always go to IDLE next cycle.
- ACK_O = (state==ACK) & REQ, so it is never asserted without a live strobe. It is high for exactly one cycle per transfer.
- Latency: ACK_O rises WAIT_STATES+1 cycles after REQ is first sampled high.
- Throughput: one beat per WAIT_STATES+2 cycles.
- Block cycles: master keeps STB_I high after ACK. The IDLE cycle following ACK starts the next beat.
- Write commit: Q updates on the clock edge ending the ACK_O cycle, only if WE_I=1. Per byte lane n with SEL_I[n]=1:
  - ADR 0: lane <= DAT_I lane.
  - ADR 1: lane <= Q lane | DAT_I lane.
  - ADR 2: lane <= Q lane & ~DAT_I lane.
  - ADR 3: lane <= Q lane ^ DAT_I lane.
  - Lanes with SEL_I[n]=0 are unchanged.
  - SEL_I=0 write is acknowledged with no change.
- Read: DAT_O=Q at all times; the master samples it in the ACK_O cycle. Reads never modify Q.
- RMW cycle: read beat then write beat within one CYC_I; each beat is handled independently.
- Aborts: CYC_I or STB_I dropping before ACK produces no ACK and no write. The FSM returns to IDLE.
- Mid-transfer changes: ADR_I, WE_I, SEL_I and DAT_I are sampled only at the commit edge.
- Reset during WAIT or ACK: immediate abort, Q=RST_VAL, ACK_O low combinationally.
- PRT_O equals DAT_O; there is no extra output pipeline stage.

Test Plan:
- Reset: DAT_W=16, RST_VAL=16'hA5A5; assert RST_I low mid-WAIT -> PRT_O=16'hA5A5 and ACK_O=0 immediately; first ACK_O only after a fresh REQ following release.
- Wait states: WAIT_STATES=2; write ADR 0, DAT_I=16'h1234, SEL_I=2'b11 -> ACK_O high exactly in cycle 3 after the strobe, for one cycle; PRT_O=16'h1234 the next cycle.
- Byte lanes and modes: Q=16'h00FF.
  - SET ADR 1, DAT_I=16'h0F00, SEL_I=2'b10 -> Q=16'h0FFF.
  - CLR ADR 2, DAT_I=16'h00F0, SEL_I=2'b01 -> Q=16'h0F0F.
  - TGL ADR 3, DAT_I=16'hFFFF, SEL_I=2'b01 -> Q=16'h0FF0.
- Abort: WAIT_STATES=3; drop STB_I after 2 cycles of a write of 16'hBEEF -> no ACK_O; Q unchanged.
- Block read/write: WAIT_STATES=0; 4-beat write burst with STB_I held, data 1,2,3,4 -> four single-cycle ACK_O pulses 2 cycles apart; final Q=4; a following read beat returns DAT_O=4.
- SEL_I=0 write of 16'hFFFF -> ACK_O asserted; Q unchanged.
